rlogic_xy_port: RTL

//  Per-input-port route unit for the 2D-mesh router. Decodes the header flit's destination and computes a dimension-order route (XY or YX).

---
 rtl/noc_pkg.sv | 30 +++
 rtl/xy_route_calc.sv | 44 ++++
 rtl/rlogic_xy_port.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit type codes, one-hot output port constants, route modes.
package noc_pkg;

  typedef enum logic [1:0] {
    FT_BODY   = 2'b00,
    FT_TAIL   = 2'b01,
    FT_HDR    = 2'b10,
    FT_SINGLE = 2'b11
  } flit_type_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } rt_state_e;

  localparam logic [4:0] P_L = 5'b00001;
  localparam logic [4:0] P_E = 5'b00010;
  localparam logic [4:0] P_W = 5'b00100;
  localparam logic [4:0] P_S = 5'b01000;
  localparam logic [4:0] P_N = 5'b10000;

  localparam int ROUTE_XY = 0;
  localparam int ROUTE_YX = 1;

  // Tail-class flits (TAIL or SINGLE) close a packet.
  function automatic logic is_tail_type(input flit_type_e t);
    return (t == FT_TAIL) || (t == FT_SINGLE);
  endfunction

endpackage

// File: rtl/xy_route_calc.sv
// Combinational dimension-order route: destination x/y -> one-hot output port.
module xy_route_calc
  import noc_pkg::*;
#(
  parameter int X_W        = 2,
  parameter int Y_W        = 2,
  parameter int CUR_X      = 1,
  parameter int CUR_Y      = 1,
  parameter int ROUTE_MODE = ROUTE_XY
) (
  input  logic [X_W-1:0] dst_x,
  input  logic [Y_W-1:0] dst_y,
  output logic [4:0]     port_oh
);

  localparam logic signed [X_W:0] CUR_X_S = CUR_X[X_W:0];
  localparam logic signed [Y_W:0] CUR_Y_S = CUR_Y[Y_W:0];

  logic x_gt_s, x_lt_s, y_gt_s, y_lt_s;

  assign x_gt_s = $signed({1'b0, dst_x}) > CUR_X_S;
  assign x_lt_s = $signed({1'b0, dst_x}) < CUR_X_S;
  assign y_gt_s = $signed({1'b0, dst_y}) > CUR_Y_S;
  assign y_lt_s = $signed({1'b0, dst_y}) < CUR_Y_S;

  // Resolve the first dimension, then the second, else deliver locally.
  always_comb begin
    port_oh = P_L;
    if (ROUTE_MODE == ROUTE_YX) begin
      if (y_gt_s)      port_oh = P_S;
      else if (y_lt_s) port_oh = P_N;
      else if (x_gt_s) port_oh = P_E;
      else if (x_lt_s) port_oh = P_W;
      else             port_oh = P_L;
    end else begin
      if (x_gt_s)      port_oh = P_E;
      else if (x_lt_s) port_oh = P_W;
      else if (y_gt_s) port_oh = P_S;
      else if (y_lt_s) port_oh = P_N;
      else             port_oh = P_L;
    end
  end

endmodule

// File: rtl/rlogic_xy_port.sv
// Per-input-port route unit: locks a dimension-order route per packet behind a 1-entry pipeline.
// Optional protocol/destination checking and the err port are enabled by `RLOGIC_PROTO_CHK_EN.
module rlogic_xy_port
  import noc_pkg::*;
#(
  parameter int X_NODES    = 4,
  parameter int Y_NODES    = 4,
  parameter int X_W        = $clog2(X_NODES),
  parameter int Y_W        = $clog2(Y_NODES),
  parameter int CUR_X      = 1,
  parameter int CUR_Y      = 1,
  parameter int FLIT_W     = 8,
  parameter int ROUTE_MODE = ROUTE_XY
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_vld,
  output logic              in_rdy,
  input  logic [FLIT_W-1:0] in_flit,
  output logic              out_vld,
  input  logic              out_rdy,
  output logic [FLIT_W-1:0] out_flit,
  output logic [4:0]        out_req,
  output logic              out_tail
`ifdef RLOGIC_PROTO_CHK_EN
  ,output logic             err
`endif
);

  rt_state_e         st_r, st_nxt_s;
  logic [4:0]        route_r, calc_port_s, new_route_s, route_sel_s;
  logic              out_vld_r, out_tail_r;
  logic [FLIT_W-1:0] out_flit_r;
  logic [4:0]        out_req_r;
  logic              acc_s, load_s, use_new_s;
  flit_type_e        ftype_s;
  logic [X_W-1:0]    dst_x_s;
  logic [Y_W-1:0]    dst_y_s;
`ifdef RLOGIC_PROTO_CHK_EN
  logic              err_r, err_set_s, dst_oob_s;
`endif

  assign in_rdy  = !out_vld_r || out_rdy;
  assign acc_s   = in_vld && in_rdy;
  assign ftype_s = flit_type_e'(in_flit[FLIT_W-1:FLIT_W-2]);
  assign dst_x_s = in_flit[X_W-1:0];
  assign dst_y_s = in_flit[X_W+Y_W-1:X_W];

  xy_route_calc #(
    .X_W        (X_W),
    .Y_W        (Y_W),
    .CUR_X      (CUR_X),
    .CUR_Y      (CUR_Y),
    .ROUTE_MODE (ROUTE_MODE)
  ) u_calc (
    .dst_x   (dst_x_s),
    .dst_y   (dst_y_s),
    .port_oh (calc_port_s)
  );

`ifdef RLOGIC_PROTO_CHK_EN
  assign dst_oob_s   = (int'(dst_x_s) >= X_NODES) || (int'(dst_y_s) >= Y_NODES);
  assign new_route_s = dst_oob_s ? P_L : calc_port_s;
`else
  assign new_route_s = calc_port_s;
`endif

  // Decode the accepted flit against the packet state: load, reroute, next state.
  always_comb begin
    load_s    = 1'b0;
    use_new_s = 1'b0;
    st_nxt_s  = st_r;
`ifdef RLOGIC_PROTO_CHK_EN
    err_set_s = 1'b0;
`endif
    if (acc_s) begin
`ifdef RLOGIC_PROTO_CHK_EN
      case (st_r)
        ST_IDLE: begin
          case (ftype_s)
            FT_HDR:    begin load_s = 1'b1; use_new_s = 1'b1; st_nxt_s = ST_BUSY; end
            FT_SINGLE: begin load_s = 1'b1; use_new_s = 1'b1; st_nxt_s = ST_IDLE; end
            default:   err_set_s = 1'b1;  // orphan BODY/TAIL is consumed and dropped
          endcase
        end
        ST_BUSY: begin
          case (ftype_s)
            FT_BODY: load_s = 1'b1;
            FT_TAIL: begin load_s = 1'b1; st_nxt_s = ST_IDLE; end
            FT_HDR:  begin load_s = 1'b1; use_new_s = 1'b1; err_set_s = 1'b1; st_nxt_s = ST_BUSY; end
            default: begin load_s = 1'b1; use_new_s = 1'b1; err_set_s = 1'b1; st_nxt_s = ST_IDLE; end
          endcase
        end
        default: st_nxt_s = ST_IDLE;
      endcase
      if (use_new_s && dst_oob_s) begin
        err_set_s = 1'b1;
      end else begin
        err_set_s = err_set_s;
      end
`else
      load_s = 1'b1;
      case (st_r)
        ST_IDLE: begin
          use_new_s = 1'b1;
          st_nxt_s  = (ftype_s == FT_SINGLE) ? ST_IDLE : ST_BUSY;
        end
        ST_BUSY: st_nxt_s = (ftype_s == FT_TAIL) ? ST_IDLE : ST_BUSY;
        default: st_nxt_s = ST_IDLE;
      endcase
`endif
    end else begin
      st_nxt_s = st_r;
    end
  end

  // Headers take the freshly computed port; the rest of the packet reuses the lock.
  always_comb begin
    if (use_new_s) route_sel_s = new_route_s;
    else           route_sel_s = route_r;
  end

  // Packet state, route lock and the registered output stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_r       <= ST_IDLE;
      route_r    <= 5'b00000;
      out_vld_r  <= 1'b0;
      out_flit_r <= {FLIT_W{1'b0}};
      out_req_r  <= 5'b00000;
      out_tail_r <= 1'b0;
`ifdef RLOGIC_PROTO_CHK_EN
      err_r      <= 1'b0;
`endif
    end else begin
      st_r <= st_nxt_s;
      if (use_new_s) route_r <= route_sel_s;
      if (load_s) begin
        out_vld_r  <= 1'b1;
        out_flit_r <= in_flit;
        out_req_r  <= route_sel_s;
        out_tail_r <= is_tail_type(ftype_s);
      end else if (out_rdy) begin
        out_vld_r  <= 1'b0;
      end
`ifdef RLOGIC_PROTO_CHK_EN
      if (err_set_s) err_r <= 1'b1;
`endif
    end
  end

  assign out_vld  = out_vld_r;
  assign out_flit = out_flit_r;
  assign out_req  = out_req_r;
  assign out_tail = out_tail_r;
`ifdef RLOGIC_PROTO_CHK_EN
  assign err      = err_r;
`endif

endmodule
